inst_mem_sync: RTL and testbench
================================

// Module: inst_mem_sync
// PURPOSE
//  Synchronous, loadable instruction memory; replaces the fixed combinational ROM in the fetch stage.
//  Two banks, selected by address bit 31: kernel (addr[31]=1) and user (addr[31]=0).
//  A boot loader fills both banks through a write port, then the block switches to RUN and serves fetches.
//  In RUN the kernel bank is write-protected.
// PARAMETERS
//  KDEPTH  64   kernel bank depth in words (power of 2, <= 16384)
//  UDEPTH  256  user bank depth in words (power of 2, <= 16384)
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  reset        in   1   asynchronous, active-high reset
//  fetch_req    in   1   fetch request
//  fetch_addr   in   32  byte address of the fetch
//  stall        in   1   pipeline stall; fetch outputs hold
//  fetch_valid  out  1   fetch_instr/fetch_fault are valid
//  fetch_instr  out  32  fetched instruction (32'h0 = nop on a fault)
//  fetch_fault  out  1   fetch was misaligned or out of range
//  ld_we        in   1   loader write strobe
//  ld_addr      in   32  loader byte address; bit 31 selects the bank
//  ld_data      in   32  loader write data
//  ld_done      in   1   loader finished (1-cycle pulse)
//  busy         out  1   1 while in LOAD state
//  ld_err       out  1   sticky; rejected loader write
// BEHAVIOUR
//  - Reset (async): state=LOAD, busy=1, fetch_valid=0, fetch_instr=0, fetch_fault=0, ld_err=0.
//    Bank contents are NOT cleared by reset.
//  - Word index idx = addr[15:2]; bits [30:16] ignored.
//    In range iff idx < KDEPTH (kernel) or idx < UDEPTH (user).
//  - FSM LOAD:
//    - Fetches are ignored; fetch_valid stays 0.
//    - ld_we with addr[1:0]==0 and idx in range writes the selected bank.
//    - Any other ld_we sets ld_err and writes nothing.
//    - ld_done -> RUN next cycle; busy drops in the same edge.
//  - FSM RUN:
//    - Write rules: user-bank writes are allowed. Any kernel-bank write sets ld_err and writes nothing.
//    - ld_done has no effect.
//    - Only reset returns the FSM to LOAD.
//  - Fetch latency: 1 cycle.
//    - fetch_req at edge N (RUN, stall=0) gives fetch_valid=1 and the data after edge N.
//    - Without a request: fetch_valid=0 next cycle and fetch_instr holds its last value.
//  - Fetch fault: addr[1:0]!=0 or idx out of range gives fetch_fault=1, fetch_instr=32'h0, fetch_valid=1.
//  - Stall:
//    - stall=1 freezes fetch_valid, fetch_instr and fetch_fault.
//    - fetch_req during a stall is dropped; the CPU re-presents the request.
//    - Loader writes are still performed during a stall.
//  - Same-address fetch and write in one cycle: read-first; the fetch returns the old word.
//  - ld_we and ld_done in the same LOAD cycle: the write is performed, then the FSM enters RUN.
//  - Reset asserted mid-fetch: outputs clear immediately and the in-flight fetch is lost.
// STRUCTURE
//  - Package inst_mem_pkg:
//    - state enum {ST_LOAD, ST_RUN}
//    - constant NOP = 32'h0
//    - function word_idx(addr)
//  - Sub-module inst_mem_bank #(DEPTH): 1R1W synchronous RAM, read-first, no reset.
//    Instantiated twice: kernel and user.
//  - Top level holds the FSM, range/alignment checks, output registers and the stall hold.
// TESTING
//  1. Reset, load kernel[0]=32'h3C084000 and user[3]=32'h8D090020, pulse ld_done:
//     - busy falls 1 cycle later.
//     - Fetch 0x80000000 returns 32'h3C084000, valid 1 cycle later.
//     - Fetch 0x0000000C returns 32'h8D090020.
//  2. In RUN, ld_we to 0x80000004:
//     - ld_err=1.
//     - A subsequent fetch of 0x80000004 returns the previously loaded value.
//  3. Fetch 0x80000002 and fetch 0x80000000+4*KDEPTH:
//     - Each returns fetch_fault=1, fetch_instr=0, fetch_valid=1.
//  4. Stall for 3 cycles with fetch_req toggling:
//     - Outputs are stable for the whole stall.
//     - The first fetch after stall=0 returns data 1 cycle later.
//  5. User write 32'hAAAA5555 to 0x10 with a same-cycle fetch of 0x10:
//     - The fetch returns the old word.
//     - The next fetch of 0x10 returns 32'hAAAA5555.
//  6. Assert reset mid-fetch in RUN:
//     - busy=1 and fetch_valid=0 immediately.
//     - After a new ld_done, earlier contents are still readable.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and helpers for the loadable instruction memory
package inst_mem_pkg;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  localparam logic [31:0] NOP   = 32'h0;
  localparam int          IDX_W = 14;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return addr[15:2];
  endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// rtl/inst_mem_bank.sv - 1R1W synchronous word RAM, read-first, contents survive reset
module inst_mem_bank #(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read and write in the same edge: rdata picks up the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - two-bank loadable instruction memory with boot-load FSM and stall hold
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int KDEPTH = 64,
  parameter int UDEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        busy,
  output logic        ld_err
);

  localparam int               KAW  = $clog2(KDEPTH);
  localparam int               UAW  = $clog2(UDEPTH);
  localparam logic [IDX_W:0]   KLIM = (IDX_W+1)'(KDEPTH);
  localparam logic [IDX_W:0]   ULIM = (IDX_W+1)'(UDEPTH);

  state_t            state, state_next;
  logic [IDX_W-1:0]  f_idx, l_idx;
  logic              f_in_range, l_in_range;
  logic              f_bad, l_ok, fetch_go;
  logic              k_we, u_we, k_re, u_re;
  logic [31:0]       k_rdata, u_rdata;
  logic              valid_q, fault_q, data_ok_q, sel_k_q, err_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{fetch_addr[30:16], ld_addr[30:16]};

  always_comb begin
    f_idx      = word_idx(fetch_addr);
    l_idx      = word_idx(ld_addr);
    f_in_range = fetch_addr[31] ? ({1'b0, f_idx} < KLIM) : ({1'b0, f_idx} < ULIM);
    l_in_range = ld_addr[31]    ? ({1'b0, l_idx} < KLIM) : ({1'b0, l_idx} < ULIM);
    f_bad      = (fetch_addr[1:0] != 2'b00) || !f_in_range;
    fetch_go   = (state == ST_RUN) && fetch_req && !stall;
    // Once running, the kernel bank is read-only.
    l_ok       = (ld_addr[1:0] == 2'b00) && l_in_range && !((state == ST_RUN) && ld_addr[31]);
    k_we       = ld_we && l_ok && ld_addr[31];
    u_we       = ld_we && l_ok && !ld_addr[31];
    k_re       = fetch_go && !f_bad && fetch_addr[31];
    u_re       = fetch_go && !f_bad && !fetch_addr[31];
  end

  always_comb begin
    state_next = state;
    if (state == ST_LOAD && ld_done) state_next = ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOAD;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      data_ok_q <= 1'b0;
      sel_k_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (ld_we && !l_ok) err_q <= 1'b1;
      if (!stall) valid_q <= fetch_go;
      if (fetch_go) begin
        fault_q   <= f_bad;
        data_ok_q <= !f_bad;
        sel_k_q   <= fetch_addr[31];
      end
    end
  end

  inst_mem_bank #(.DEPTH(KDEPTH)) u_kernel (
    .clk   (clk),
    .we    (k_we),
    .waddr (l_idx[KAW-1:0]),
    .wdata (ld_data),
    .re    (k_re),
    .raddr (f_idx[KAW-1:0]),
    .rdata (k_rdata)
  );

  inst_mem_bank #(.DEPTH(UDEPTH)) u_user (
    .clk   (clk),
    .we    (u_we),
    .waddr (l_idx[UAW-1:0]),
    .wdata (ld_data),
    .re    (u_re),
    .raddr (f_idx[UAW-1:0]),
    .rdata (u_rdata)
  );

  // Bank read registers only move on an accepted in-range fetch, so the hold comes for free.
  assign fetch_instr = data_ok_q ? (sel_k_q ? k_rdata : u_rdata) : NOP;
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;
  assign busy        = (state == ST_LOAD);
  assign ld_err      = err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - randomized self-checking bench for inst_mem_sync against a reference model
module tb_inst_mem_sync;

  localparam int KDEPTH = 64;
  localparam int UDEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        busy;
  logic        ld_err;

  always #5 clk = ~clk;

  inst_mem_sync #(.KDEPTH(KDEPTH), .UDEPTH(UDEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .busy        (busy),
    .ld_err      (ld_err)
  );

  logic [31:0] kmem [KDEPTH];
  logic [31:0] umem [UDEPTH];
  bit          m_run, m_valid, m_fault, m_err;
  logic [31:0] m_instr;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    int idx;
    idx = int'(a[15:2]);
    return (a[1:0] == 2'b00) && (a[31] ? (idx < KDEPTH) : (idx < UDEPTH));
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx;
    idx = int'(a[15:2]);
    return a[31] ? kmem[idx] : umem[idx];
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[15:2]);
    if (a[31]) kmem[idx] = d;
    else       umem[idx] = d;
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_fault = 0; m_err = 0; m_instr = 32'h0;
  endtask

  // One rising edge of the reference: fetch sees memory before this edge's write.
  task automatic model_edge();
    bit bad;
    if (m_run && !stall) begin
      m_valid = fetch_req;
      if (fetch_req) begin
        bad     = !addr_ok(fetch_addr);
        m_fault = bad;
        m_instr = bad ? 32'h0 : mem_rd(fetch_addr);
      end
    end
    if (ld_we) begin
      if (addr_ok(ld_addr) && !(m_run && ld_addr[31])) mem_wr(ld_addr, ld_data);
      else m_err = 1;
    end
    if (!m_run && ld_done) m_run = 1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, 32'(fetch_valid), 32'(m_valid));
    check_eq({tag, ".instr"}, fetch_instr, m_instr);
    check_eq({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
    check_eq({tag, ".busy"},  32'(busy), 32'(!m_run));
    check_eq({tag, ".err"},   32'(ld_err), 32'(m_err));
  endtask

  task automatic step(input string tag, input bit req, input logic [31:0] fa, input bit st,
                      input bit we, input logic [31:0] la, input logic [31:0] ld, input bit dn);
    fetch_req = req; fetch_addr = fa; stall = st;
    ld_we = we; ld_addr = la; ld_data = ld; ld_done = dn;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic        bank;
    int          kind, depth;
    logic [13:0] idx;
    logic [1:0]  lo;
    bank  = 1'($urandom_range(0, 1));
    kind  = $urandom_range(0, 9);
    depth = bank ? KDEPTH : UDEPTH;
    lo    = 2'b00;
    if (kind == 9) idx = 14'(depth + $urandom_range(0, 16383 - depth));
    else           idx = 14'($urandom_range(0, depth - 1));
    if (kind == 8) lo = 2'($urandom_range(1, 3));
    return {bank, 15'($urandom), idx, lo};
  endfunction

  initial begin
    logic [31:0] old_word, fa, la;
    fetch_req = 0; fetch_addr = 0; stall = 0;
    ld_we = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
    reset = 1;
    #12;
    model_reset();
    check_all("reset");
    check_eq("reset.busy_const", 32'(busy), 32'd1);
    reset = 0;

    for (int i = 0; i < KDEPTH; i++)
      step("fill_k", 0, 32'h0, 0, 1, 32'h8000_0000 | 32'(i << 2), $urandom, 0);
    for (int i = 0; i < UDEPTH; i++)
      step("fill_u", 0, 32'h0, 0, 1, 32'(i << 2), $urandom, 0);

    step("t1_wk", 1, 32'h8000_0000, 0, 1, 32'h8000_0000, 32'h3C08_4000, 0);
    step("t1_wu", 0, 32'h0, 0, 1, 32'h0000_000C, 32'h8D09_0020, 0);
    check_eq("t1_busy_load", 32'(busy), 32'd1);
    step("t1_done", 0, 32'h0, 0, 1, 32'h0000_0020, 32'h1234_5678, 1);
    check_eq("t1_busy_run", 32'(busy), 32'd0);
    step("t1_fk", 1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 0);
    check_eq("t1_k0", fetch_instr, 32'h3C08_4000);
    step("t1_fu", 1, 32'h0000_000C, 0, 0, 32'h0, 32'h0, 0);
    check_eq("t1_u3", fetch_instr, 32'h8D09_0020);
    idle("t1_idle");
    check_eq("t1_hold", fetch_instr, 32'h8D09_0020);

    old_word = kmem[1];
    step("t2_wk", 0, 32'h0, 0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 0);
    check_eq("t2_err", 32'(ld_err), 32'd1);
    step("t2_fk", 1, 32'h8000_0004, 0, 0, 32'h0, 32'h0, 0);
    check_eq("t2_protected", fetch_instr, old_word);

    step("t3_mis", 1, 32'h8000_0002, 0, 0, 32'h0, 32'h0, 0);
    check_eq("t3_mis_fault", 32'(fetch_fault), 32'd1);
    step("t3_oor", 1, 32'h8000_0000 + 32'(4 * KDEPTH), 0, 0, 32'h0, 32'h0, 0);
    check_eq("t3_oor_fault", 32'(fetch_fault), 32'd1);
    check_eq("t3_oor_instr", fetch_instr, 32'h0);

    step("t4_pre", 1, 32'h0000_0008, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      step("t4_stall", i[0] == 1'b0, 32'h0000_0004 * 32'(i + 5), 1, 0, 32'h0, 32'h0, 0);
    step("t4_post", 1, 32'h0000_0004, 0, 0, 32'h0, 32'h0, 0);

    old_word = umem[4];
    step("t5_rf", 1, 32'h0000_0010, 0, 1, 32'h0000_0010, 32'hAAAA_5555, 0);
    check_eq("t5_old", fetch_instr, old_word);
    step("t5_new", 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0, 0);
    check_eq("t5_new_const", fetch_instr, 32'hAAAA_5555);

    for (int i = 0; i < 400; i++) begin
      fa = rand_addr();
      la = ($urandom_range(0, 3) == 0) ? fa : rand_addr();
      step("rand_run", $urandom_range(0, 3) != 0, fa, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, la, $urandom, $urandom_range(0, 9) == 0);
    end

    step("t6_fetch", 1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 0);
    #2 reset = 1;
    #1;
    model_reset();
    check_all("t6_rst");
    check_eq("t6_valid_const", 32'(fetch_valid), 32'd0);
    #2 reset = 0;

    step("t6_bad_mis", 0, 32'h0, 0, 1, 32'h8000_0001, 32'h1, 0);
    check_eq("t6_err_load", 32'(ld_err), 32'd1);
    step("t6_bad_oor", 1, 32'h8000_0000, 0, 1, 32'h8000_0000 + 32'(4 * KDEPTH), 32'h2, 0);
    step("t6_done", 0, 32'h0, 0, 1, 32'h8000_0008, 32'hCAFE_F00D, 1);
    for (int i = 0; i < KDEPTH; i++)
      step("t6_rk", 1, 32'h8000_0000 | 32'(i << 2), 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < UDEPTH; i += 7)
      step("t6_ru", 1, 32'(i << 2), 0, 0, 32'h0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
